// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants, the counter-width helper and the
// per-channel edge-flag struct for the debounce bank.
package debounce_pkg;

  // Legal parameter ranges for the bank.
  localparam int CHANNELS_MIN  = 1;
  localparam int CHANNELS_MAX  = 32;
  localparam int MAX_COUNT_MIN = 2;
  localparam int MAX_COUNT_MAX = 65536;

  // Edge pulses produced by a channel on the cycle its output changes.
  typedef struct packed {
    logic edj;
    logic rise;
    logic fall;
  } edge_flags_t;

  // Counter width: enough bits to hold 0..max_count-1, never less than one.
  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one debounce channel. Optional two-flop synchroniser
// (macro DEBOUNCE_SYNC_EN), a stability counter, the debounced level and
// registered edge pulses that line up with the output change.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   MAX_COUNT   = 16,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in,
  output logic        o_out,
  output edge_flags_t o_flags
);

  localparam int             CW   = cnt_width(MAX_COUNT);
  localparam logic [CW-1:0]  TERM = CW'(MAX_COUNT - 1);

  logic          w_s;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  edge_flags_t   r_flags;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_out_nxt;
  edge_flags_t   w_flags_nxt;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchroniser for an input that is asynchronous to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {2{RESET_LEVEL}};
    else          r_sync <= {r_sync[0], i_in};
  end

  assign w_s = r_sync[1];
`else
  assign w_s = i_in;
`endif

  // Next state: agreement clears the count, terminal count accepts the change.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_flags_nxt = '0;
    if (w_s == r_out) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == TERM) begin
      w_cnt_nxt        = '0;
      w_out_nxt        = w_s;
      w_flags_nxt.edj  = w_s ^ r_out;
      w_flags_nxt.rise = w_s & ~r_out;
      w_flags_nxt.fall = ~w_s & r_out;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Counter, debounced level and edge pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_out   <= RESET_LEVEL;
      r_flags <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  assign o_out   = r_out;
  assign o_flags = r_flags;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent debounce channels plus sticky
// per-channel event bits (write-1-to-clear) and a registered interrupt.
// Macro DEBOUNCE_SYNC_EN adds a two-flop input synchroniser per channel.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int MAX_COUNT   = 16,
  parameter int RESET_LEVEL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] edj,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] pend,
  output logic                irq
);

  edge_flags_t         w_flags [CHANNELS];
  logic [CHANNELS-1:0] r_pend;
  logic                r_irq;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    debounce_chan #(
      .MAX_COUNT   (MAX_COUNT),
      .RESET_LEVEL (1'(RESET_LEVEL))
    ) u_chan (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_in    (in[gi]),
      .o_out   (out[gi]),
      .o_flags (w_flags[gi])
    );
    assign edj[gi]  = w_flags[gi].edj;
    assign rise[gi] = w_flags[gi].rise;
    assign fall[gi] = w_flags[gi].fall;
  end

  // Sticky event bits (a new edge beats a clear) and the interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~clr) | edj;
      r_irq  <= |r_pend;
    end
  end

  assign pend = r_pend;
  assign irq  = r_irq;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: bench for debounce_bank (CHANNELS=4, MAX_COUNT=16).
// Honours DEBOUNCE_SYNC_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_debounce_bank;

  localparam int CH = 4;
  localparam int MC = 16;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = MC + 2;
`else
  localparam int LAT = MC;
`endif

  // ---------------- clock / reset ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] in_v  = '0;
  logic [CH-1:0] clr_v = '0;
  logic [CH-1:0] out_w, edj_w, rise_w, fall_w, pend_w;
  logic          irq_w;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS    (CH),
    .MAX_COUNT   (MC),
    .RESET_LEVEL (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_v),
    .out   (out_w),
    .edj   (edj_w),
    .rise  (rise_w),
    .fall  (fall_w),
    .clr   (clr_v),
    .pend  (pend_w),
    .irq   (irq_w)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A channel's output takes the opposite level once its last MC samples
  // (taken since reset) all differ from the current output.
  logic [CH-1:0] m_out  = '0;
  logic [CH-1:0] m_edj  = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  logic [CH-1:0] m_pend = '0;
  logic          m_irq  = 1'b0;
  logic [CH-1:0] m_s1   = '0;
  logic [CH-1:0] m_s2   = '0;
  logic [CH-1:0] m_smp;
  logic [MC-1:0] m_hist [CH];
  int            m_nsamp [CH] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out  = '0;
      m_edj  = '0;
      m_rise = '0;
      m_fall = '0;
      m_pend = '0;
      m_irq  = 1'b0;
      m_s1   = '0;
      m_s2   = '0;
      for (int i = 0; i < CH; i++) m_nsamp[i] = 0;
    end else begin
      m_irq  = |m_pend;
      m_pend = (m_pend & ~clr_v) | m_edj;
`ifdef DEBOUNCE_SYNC_EN
      m_smp = m_s2;
      m_s2  = m_s1;
      m_s1  = in_v;
`else
      m_smp = in_v;
`endif
      m_edj  = '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < CH; i++) begin
        m_hist[i] = {m_hist[i][MC-2:0], m_smp[i]};
        if (m_nsamp[i] < MC) m_nsamp[i]++;
        if (m_nsamp[i] == MC && m_hist[i] == {MC{~m_out[i]}}) begin
          m_out[i]  = ~m_out[i];
          m_edj[i]  = 1'b1;
          m_rise[i] = m_out[i];
          m_fall[i] = ~m_out[i];
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("out",  out_w,  m_out);
      check("edj",  edj_w,  m_edj);
      check("rise", rise_w, m_rise);
      check("fall", fall_w, m_fall);
      check("pend", pend_w, m_pend);
      check("irq",  irq_w,  m_irq);
      check("rise_and_fall", rise_w & fall_w, 0);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_out",  out_w,  0);
    check("rst_pend", pend_w, 0);
    check("rst_irq",  irq_w,  0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single rising edge on channel 0.
    in_v[0] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check("t1_out_early", out_w[0], 0);
    @(negedge clk);
    check("t1_out",  out_w[0],  1);
    check("t1_rise", rise_w[0], 1);
    check("t1_edj",  edj_w[0],  1);
    @(negedge clk);
    check("t1_rise_off", rise_w[0], 0);
    check("t1_pend",     pend_w[0], 1);
    check("t1_irq_early", irq_w, 0);
    @(negedge clk);
    check("t1_irq", irq_w, 1);

    // Channel 1 bounces: 15 high, 1 low, five times.
    for (int r = 0; r < 5; r++) begin
      in_v[1] = 1'b1;
      repeat (15) @(negedge clk);
      in_v[1] = 1'b0;
      @(negedge clk);
    end
    repeat (LAT) @(negedge clk);
    check("t2_out",  out_w[1],  0);
    check("t2_pend", pend_w[1], 0);

    // All channels swap on the same cycle.
    in_v = 4'b0101;
    repeat (LAT + 4) @(negedge clk);
    check("t3_settle", out_w, 4'b0101);
    in_v = 4'b1010;
    repeat (LAT - 1) @(negedge clk);
    check("t3_edj_early", edj_w, 0);
    @(negedge clk);
    check("t3_rise", rise_w, 4'b1010);
    check("t3_fall", fall_w, 4'b0101);
    check("t3_edj",  edj_w,  4'b1111);
    check("t3_out",  out_w,  4'b1010);

    // Clear all but channel 2, then a new edge on 2 meets a clear of 2.
    @(negedge clk);
    clr_v = 4'b1011;
    @(negedge clk);
    clr_v = '0;
    check("t4_pend_only2", pend_w, 4'b0100);
    in_v[2] = 1'b1;
    repeat (LAT) @(negedge clk);
    check("t4_edj2", edj_w[2], 1);
    clr_v[2] = 1'b1;
    @(negedge clk);
    clr_v = '0;
    check("t4_set_wins", pend_w[2], 1);
    clr_v[2] = 1'b1;
    @(negedge clk);
    clr_v = '0;
    check("t4_cleared", pend_w, 0);
    @(negedge clk);
    check("t4_irq_low", irq_w, 0);

    // Reset at count 10 of a rising transition on channel 0.
    in_v[0] = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_out",  out_w,  0);
    check("t5_edj",  edj_w,  0);
    check("t5_rise", rise_w, 0);
    check("t5_fall", fall_w, 0);
    check("t5_pend", pend_w, 0);
    check("t5_irq",  irq_w,  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check("t5_out_early", out_w, 0);
    @(negedge clk);
    check("t5_out_after", out_w,  4'b1111);
    check("t5_rise_after", rise_w, 4'b1111);

    // Random noisy inputs, random clears, rare resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 19) == 0) in_v[i] = ~in_v[i];
      clr_v = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1;
    clr_v = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 8: number of independent debounce channels, range 1..32.
REQ-002 Parameter MAX_COUNT, default 16: consecutive differing samples needed to accept a change, range 2..65536.
REQ-003 Parameter RESET_LEVEL, default 0: per-bank reset value of out, 0 or 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in  input  CHANNELS  noisy inputs, one bit per channel.
REQ-007 out  output  CHANNELS  debounced level per channel.
REQ-008 edj  output  CHANNELS  one-cycle pulse on either edge of out.
REQ-009 rise  output  CHANNELS  one-cycle pulse on rising edge of out.
REQ-010 fall  output  CHANNELS  one-cycle pulse on falling edge of out.
REQ-011 clr  input  CHANNELS  write-1-to-clear for sticky event bits.
REQ-012 pend  output  CHANNELS  sticky event bit per channel, set by any accepted edge.
REQ-013 irq  output  1  OR of all pend bits, registered.

Function
REQ-014 Each channel shall own a counter of width $clog2(MAX_COUNT), independent of all other channels.
REQ-015 Sampled input s (see REQ-028) differing from out shall increment the counter by 1 per cycle.
REQ-016 s equal to out shall return the counter to 0 in the same cycle (hysteresis; partial counts discarded).
REQ-017 Counter at MAX_COUNT-1 shall load out from s, return the counter to 0, and drive edj/rise/fall from s^out, s&~out, ~s&out on the same edge.
REQ-018 A change held stable on s shall appear on out exactly MAX_COUNT cycles after the first differing sample.
REQ-019 If s equals out on the terminal-count cycle, out shall stay unchanged and no pulse shall issue.
REQ-020 edj, rise, fall shall be high for exactly one cycle per accepted edge; rise and fall never both high on one channel.
REQ-021 pend[i] shall set on the cycle following edj[i]; clr[i]=1 clears it; simultaneous set and clear: set wins.
REQ-022 irq shall equal |pend delayed by one cycle.
REQ-023 Counter shall never wrap; terminal count always takes precedence over increment.

Reset
REQ-024 rst_n low shall asynchronously force: counters 0, out all RESET_LEVEL, edj/rise/fall 0, pend 0, irq 0, synchroniser flops RESET_LEVEL.
REQ-025 rst_n deassertion shall be taken synchronously; the first count may begin on the first edge after release.
REQ-026 Reset mid-count shall discard the partial count with no edge pulse, no pend set.
REQ-027 No pulse shall issue on reset release, even when in differs from RESET_LEVEL; the difference is debounced normally.

Configuration
REQ-028 Macro DEBOUNCE_SYNC_EN defined: each in bit shall pass a two-flop synchroniser and s is its output, adding 2 cycles to REQ-018 latency (MAX_COUNT+2 from in).
REQ-029 Macro DEBOUNCE_SYNC_EN undefined: s = in directly; in shall be synchronous to clk; latency MAX_COUNT.

Structure
REQ-030 Package debounce_pkg shall hold the counter-width function, the CHANNELS and MAX_COUNT legal-range constants, and the edge-flag struct (edj, rise, fall).
REQ-031 Sub-module debounce_chan shall implement one channel (synchroniser, counter, out, pulses); debounce_bank instantiates CHANNELS copies via generate and adds pend/clr/irq logic.

Verification
REQ-032 CHANNELS=4, MAX_COUNT=16, sync off: in[0] 0->1 held -> out[0]=1 and rise[0]=1 exactly 16 cycles later, one cycle wide; pend[0]=1 next cycle; irq=1 the cycle after.
REQ-033 in[1] toggles for 15 cycles high, 1 low, repeated 5 times -> out[1] stays 0, no pulse, pend[1]=0.
REQ-034 All four channels change on the same cycle, in=4'b1010 from 4'b0101 after settling -> rise=4'b1010 and fall=4'b0101 on the same cycle, edj=4'b1111.
REQ-035 pend[2] set while clr[2] pulsed on the same cycle as a new edge on channel 2 -> pend[2] stays 1; clr[2] alone next cycle -> pend[2]=0, irq=0 one cycle later.
REQ-036 rst_n pulsed low at count 10 of a rising transition -> all outputs at reset values immediately; after release with in held 1, out=1 16 cycles later.
REQ-037 DEBOUNCE_SYNC_EN defined, MAX_COUNT=2: single-cycle in glitch -> no change; held change -> out updates 4 cycles after in.
